id_ex_stage: RTL and testbench
==============================

# id_ex_stage

- Decode/operand stage of the RV32I core, sitting directly upstream of the ALU.
- Takes a fetched instruction plus register-file read data and produces the registered `funct7`, `funct3`, `A` and `B` that drive the ALU for one cycle per instruction.
- Performs immediate generation, operand selection and EX/MEM and MEM/WB forwarding.
- Uses a single-entry valid/ready pipeline register with flush.

## Interface
Parameters:
- `XLEN`, 32, datapath width (only 32 supported)

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  fetch offers `in_instr`/`in_pc`
- `in_ready`  out  1  stage accepts this cycle
- `in_instr`  in  32  instruction word
- `in_pc`  in  32  instruction address
- `rs1_addr`, `rs2_addr`  out  5 each  combinational, `in_instr[19:15]` / `in_instr[24:20]`
- `rs1_data`, `rs2_data`  in  32 each  register-file read data, same cycle as the address
- `exm_we`, `exm_rd`, `exm_data`  in  1/5/32  EX/MEM writeback in flight
- `wb_we`, `wb_rd`, `wb_data`  in  1/5/32  MEM/WB writeback in flight
- `flush`  in  1  kill held and incoming instruction
- `out_valid`  out  1  ALU operands valid
- `out_ready`  in  1  downstream accepts
- `funct7`  out  7  to ALU
- `funct3`  out  3  to ALU
- `A`, `B`  out  32 each  ALU operands
- `rd`  out  5  destination register
- `reg_we`  out  1  write-enable for `rd` (0 when `rd`=0)
- `illegal`  out  1  unsupported opcode (held with `out_valid`)

## Operation
Supported opcodes:
- OP (0110011): `A`=rs1, `B`=rs2, `funct7`/`funct3` taken from the instruction.
- OP-IMM (0010011), general case: `A`=rs1, `B`=sign-extended `instr[31:20]`, `funct3`=`instr[14:12]`, `funct7`=0 so that ADDI is never decoded as SUB.
- OP-IMM with `funct3`=001 or 101: `funct7`=`instr[31:25]`, `B`={27'b0, `instr[24:20]`}.
- LUI (0110111): `A`=0, `B`={`instr[31:12]`, 12'b0}, `funct7`=0, `funct3`=000.
- AUIPC (0010111): `A`=`in_pc`, `B` as LUI, ADD encoding.
- Any other opcode: `illegal`=1, `reg_we`=0, `funct7`/`funct3`/`A`/`B`=0.

Operand read rules:
- `rs`=0 always reads 0; it is never forwarded.
- Forwarding priority, per operand: EX/MEM match (`exm_we`, `exm_rd`=rs, rs≠0), then MEM/WB match, then register file.

Handshake:
- `in_ready` = !`out_valid` | `out_ready` (further gated by the hazard term when forwarding is compiled out).
- Load occurs when `in_valid` & `in_ready` & !`flush`.
- If not loading and `out_ready`, `out_valid` clears.
- `flush` has priority: `out_valid`←0 next edge and the incoming instruction is dropped (its `in_ready` is still asserted, so it is consumed).
- Payload holds stable while `out_valid` & !`out_ready`.

## Timing
- Latency: 1 cycle from accepted input to `out_valid`.
- Throughput: 1 instruction/cycle.
- All outputs except `in_ready`, `rs1_addr` and `rs2_addr` are registered.
- Reset (asynchronous, immediate): `out_valid`=0, `illegal`=0, `reg_we`=0, `rd`=0, `funct7`=0, `funct3`=0, `A`=0, `B`=0.
- Reset deasserted mid-stream: the first accept can occur in the cycle after deassertion.
- Forwarding sources are sampled in the accept cycle only. A held (stalled) entry is not re-forwarded, so the upstream writeback pipeline must stall in step.
- Simultaneous flush and `out_ready`: entry is dropped, nothing is accepted.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as above.
- `ID_EX_FORWARDING_EN` undefined: forwarding muxes are removed and operands come from `rs*_data` only. A RAW hazard exists when `exm_we`/`wb_we` targets a nonzero rs used by the instruction; `in_ready` is then 0 until it clears. LUI/AUIPC never hazard; OP-IMM checks rs1 only.

## Structure
- Shared package `core_pkg`:
  - opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC)
  - funct3 constants (F3_ADD … F3_AND)
  - F7_SUB_SRA = 7'b0100000
  - `imm_sel_t` enum {IMM_NONE, IMM_I, IMM_SH, IMM_U}
- Sub-module `imm_gen`: combinational, takes instruction and `imm_sel_t`, returns 32-bit immediate.
- Forwarding and pipeline register stay in the top.

## Test plan
- ADDI x1,x2,-1 with `rs1_data`=5, no forwarding: `out_valid` next cycle, `A`=5, `B`=0xFFFF_FFFF, `funct7`=0, `funct3`=000; ALU result 4.
- SRAI `imm[11:5]`=0100000, shamt 4, rs1=0xF000_0000: `funct7`=0100000, `funct3`=101, `B`=4; ALU result 0xFF00_0000.
- SUB rs1=x3 with `exm_rd`=3 `exm_data`=30 and `wb_rd`=3 `wb_data`=99 in the same cycle: `A`=30 (EX/MEM wins). With rs1=x0 and `exm_rd`=0: `A`=0.
- AUIPC imm 0x12345 at pc 0x100: `A`=0x100, `B`=0x1234_5000, ADD encoding.
- `out_ready`=0 for 3 cycles with `in_valid` held: `in_ready`=0 and payload stable; then `out_ready`=1 gives one accept per cycle. `flush` while held: `out_valid`=0 next cycle.
- Opcode 1100011: `illegal`=1, `reg_we`=0. Assert `rst` mid-stream: all outputs return to 0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I decode constants and the immediate-format selector used by
// the decode/operand stage.
package core_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_SUB_SRA = 7'b0100000;

    typedef enum logic [1:0] {
        IMM_NONE,
        IMM_I,
        IMM_SH,
        IMM_U
    } imm_sel_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: I-type (sign-extended), shift
// amount (zero-extended shamt) and U-type (upper 20 bits) formats.
module imm_gen
    import core_pkg::*;
(
    input  logic [31:0] instr_i,
    input  imm_sel_t    sel_i,
    output logic [31:0] imm_o
);

    // The low instruction bits never carry immediate data for these formats.
    logic unusedLowBits;
    assign unusedLowBits = ^instr_i[11:0];

    always_comb begin
        imm_o = '0;
        case (sel_i)
            IMM_I:   imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_SH:  imm_o = {27'b0, instr_i[24:20]};
            IMM_U:   imm_o = {instr_i[31:12], 12'b0};
            default: imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode/operand stage feeding the ALU through a one-entry valid/ready
// register. Define ID_EX_FORWARDING_EN for EX/MEM and MEM/WB bypassing;
// without it, RAW hazards stall the stage instead.
module id_ex_stage
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            exm_we,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      funct7,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [4:0]      rd,
    output logic            reg_we,
    output logic            illegal
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] rs1Val, rs2Val, imm;
    imm_sel_t        immSel;
    logic            stageFree, load;

    logic            outValid_q, regWe_q, illegal_q;
    logic [6:0]      funct7_q, funct7_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]      rd_q;
    logic            regWe_d, illegal_d;

    assign opcode    = in_instr[6:0];
    assign rs1_addr  = in_instr[19:15];
    assign rs2_addr  = in_instr[24:20];
    assign stageFree = !outValid_q || out_ready;

`ifdef ID_EX_FORWARDING_EN
    // x0 is hardwired and never bypassed; the youngest writer (EX/MEM) wins.
    always_comb begin
        rs1Val = rs1_data;
        if (rs1_addr == 5'd0)                      rs1Val = '0;
        else if (exm_we && (exm_rd == rs1_addr))   rs1Val = exm_data;
        else if (wb_we && (wb_rd == rs1_addr))     rs1Val = wb_data;
        rs2Val = rs2_data;
        if (rs2_addr == 5'd0)                      rs2Val = '0;
        else if (exm_we && (exm_rd == rs2_addr))   rs2Val = exm_data;
        else if (wb_we && (wb_rd == rs2_addr))     rs2Val = wb_data;
    end

    assign in_ready = stageFree;
`else
    logic rs1Hit, rs2Hit, rawHazard, unusedFwdData;

    assign unusedFwdData = ^{exm_data, wb_data};
    assign rs1Val = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2Val = (rs2_addr == 5'd0) ? '0 : rs2_data;

    assign rs1Hit = (rs1_addr != 5'd0) &&
                    ((exm_we && (exm_rd == rs1_addr)) || (wb_we && (wb_rd == rs1_addr)));
    assign rs2Hit = (rs2_addr != 5'd0) &&
                    ((exm_we && (exm_rd == rs2_addr)) || (wb_we && (wb_rd == rs2_addr)));

    // Only register sources the instruction actually reads can stall it.
    always_comb begin
        rawHazard = 1'b0;
        case (opcode)
            OPC_OP:     rawHazard = rs1Hit || rs2Hit;
            OPC_OP_IMM: rawHazard = rs1Hit;
            default:    rawHazard = 1'b0;
        endcase
    end

    assign in_ready = stageFree && !rawHazard;
`endif

    always_comb begin
        immSel = IMM_NONE;
        case (opcode)
            OPC_OP_IMM: immSel = ((in_instr[14:12] == F3_SLL) || (in_instr[14:12] == F3_SR))
                                 ? IMM_SH : IMM_I;
            OPC_LUI,
            OPC_AUIPC:  immSel = IMM_U;
            default:    immSel = IMM_NONE;
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i (in_instr),
        .sel_i   (immSel),
        .imm_o   (imm)
    );

    // Non-shift OP-IMM forces funct7 to zero so ADDI can never look like SUB.
    always_comb begin
        funct7_d  = '0;
        funct3_d  = F3_ADD;
        a_d       = '0;
        b_d       = '0;
        illegal_d = 1'b0;
        case (opcode)
            OPC_OP: begin
                a_d      = rs1Val;
                b_d      = rs2Val;
                funct7_d = in_instr[31:25];
                funct3_d = in_instr[14:12];
            end
            OPC_OP_IMM: begin
                a_d      = rs1Val;
                b_d      = imm;
                funct3_d = in_instr[14:12];
                if (immSel == IMM_SH) funct7_d = in_instr[31:25];
            end
            OPC_LUI: b_d = imm;
            OPC_AUIPC: begin
                a_d = in_pc;
                b_d = imm;
            end
            default: illegal_d = 1'b1;
        endcase
        regWe_d = !illegal_d && (in_instr[11:7] != 5'd0);
    end

    assign load = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid_q <= 1'b0;
            funct7_q   <= '0;
            funct3_q   <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            regWe_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else if (load) begin
            outValid_q <= 1'b1;
            funct7_q   <= funct7_d;
            funct3_q   <= funct3_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= in_instr[11:7];
            regWe_q    <= regWe_d;
            illegal_q  <= illegal_d;
        end else if (flush || out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign out_valid = outValid_q;
    assign funct7    = funct7_q;
    assign funct3    = funct3_q;
    assign A         = a_q;
    assign B         = b_q;
    assign rd        = rd_q;
    assign reg_we    = regWe_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a reference decoder pushes expected ALU
// operands on every accept and the held entry is compared each cycle.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] in_instr, in_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        exm_we, wb_we;
    logic [4:0]  exm_rd, wb_rd;
    logic [31:0] exm_data, wb_data;
    logic        flush;
    logic        out_valid, out_ready;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] A, B;
    logic [4:0]  rd;
    logic        reg_we, illegal;

    typedef struct {
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    logic expValid = 1'b0;
    int   total = 0;
    int   bad   = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .funct7(funct7), .funct3(funct3), .A(A), .B(B),
        .rd(rd), .reg_we(reg_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, r2, r1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] d);
        return {imm, r1, f3, d, 7'b0010011};
    endfunction

    function automatic logic [31:0] uType(input logic [19:0] imm, input logic [4:0] d,
                                          input logic [6:0] opc);
        return {imm, d, opc};
    endfunction

    function automatic logic [31:0] modelOperand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 5'd0) return 32'h0;
`ifdef ID_EX_FORWARDING_EN
        if (exm_we && exm_rd == rs) return exm_data;
        if (wb_we && wb_rd == rs) return wb_data;
`endif
        return rf;
    endfunction

    function automatic logic modelHazard();
`ifdef ID_EX_FORWARDING_EN
        return 1'b0;
`else
        logic [4:0] s1, s2;
        logic h1, h2;
        s1 = in_instr[19:15];
        s2 = in_instr[24:20];
        h1 = (s1 != 0) && ((exm_we && exm_rd == s1) || (wb_we && wb_rd == s1));
        h2 = (s2 != 0) && ((exm_we && exm_rd == s2) || (wb_we && wb_rd == s2));
        if (in_instr[6:0] == 7'b0110011) return h1 | h2;
        if (in_instr[6:0] == 7'b0010011) return h1;
        return 1'b0;
`endif
    endfunction

    function automatic exp_t modelDecode();
        exp_t e;
        logic [2:0] f3;
        e = '{f7: 7'h0, f3: 3'h0, a: 32'h0, b: 32'h0, rd: in_instr[11:7], we: 1'b0, ill: 1'b0};
        f3 = in_instr[14:12];
        case (in_instr[6:0])
            7'b0110011: begin
                e.a  = modelOperand(in_instr[19:15], rs1_data);
                e.b  = modelOperand(in_instr[24:20], rs2_data);
                e.f7 = in_instr[31:25];
                e.f3 = f3;
            end
            7'b0010011: begin
                e.a  = modelOperand(in_instr[19:15], rs1_data);
                e.f3 = f3;
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    e.f7 = in_instr[31:25];
                    e.b  = {27'h0, in_instr[24:20]};
                end else begin
                    e.b  = {{20{in_instr[31]}}, in_instr[31:20]};
                end
            end
            7'b0110111: e.b = {in_instr[31:12], 12'h0};
            7'b0010111: begin
                e.a = in_pc;
                e.b = {in_instr[31:12], 12'h0};
            end
            default: e.ill = 1'b1;
        endcase
        e.we = !e.ill && (in_instr[11:7] != 5'd0);
        return e;
    endfunction

    // One clock: check handshake and held payload mid-cycle, then advance the model.
    task automatic cycle();
        logic expReady, acc;
        exp_t e;
        @(negedge clk);
        expReady = (!expValid || out_ready) && !modelHazard();
        checkOutput("in_ready", in_ready, expReady);
        checkOutput("rs1_addr", rs1_addr, in_instr[19:15]);
        checkOutput("rs2_addr", rs2_addr, in_instr[24:20]);
        checkOutput("out_valid", out_valid, expValid);
        if (expValid && sb.size() != 0) begin
            e = sb[0];
            checkOutput("funct7", funct7, e.f7);
            checkOutput("funct3", funct3, e.f3);
            checkOutput("A", A, e.a);
            checkOutput("B", B, e.b);
            checkOutput("rd", rd, e.rd);
            checkOutput("reg_we", reg_we, e.we);
            checkOutput("illegal", illegal, e.ill);
        end
        acc = in_valid && expReady && !flush;
        e = modelDecode();
        @(posedge clk);
        if (expValid && (flush || out_ready) && sb.size() != 0) void'(sb.pop_front());
        if (acc) begin
            sb.push_back(e);
            expValid = 1'b1;
        end else if (flush || out_ready) begin
            expValid = 1'b0;
        end
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] r1, input logic [31:0] r2);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        rs1_data = r1;
        rs2_data = r2;
        cycle();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".out_valid"}, out_valid, 32'h0);
        checkOutput({tag, ".illegal"}, illegal, 32'h0);
        checkOutput({tag, ".reg_we"}, reg_we, 32'h0);
        checkOutput({tag, ".rd"}, rd, 32'h0);
        checkOutput({tag, ".funct7"}, funct7, 32'h0);
        checkOutput({tag, ".funct3"}, funct3, 32'h0);
        checkOutput({tag, ".A"}, A, 32'h0);
        checkOutput({tag, ".B"}, B, 32'h0);
    endtask

    initial begin
        logic [31:0] rInstr;
        rst = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
        exm_we = 1'b0; exm_rd = 5'd0; exm_data = 32'h0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
        #12;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        applyStimulus(iType(12'hFFF, 5'd2, 3'b000, 5'd1), 32'h0, 32'd5, 32'h0);
        applyStimulus(iType({7'b0100000, 5'd4}, 5'd6, 3'b101, 5'd5), 32'h0, 32'hF000_0000, 32'h0);
        applyStimulus(iType({7'b0000000, 5'd31}, 5'd6, 3'b001, 5'd5), 32'h0, 32'h1, 32'h0);
        applyStimulus(iType(12'h7FF, 5'd9, 3'b111, 5'd0), 32'h0, 32'hFFFF_0000, 32'h0);

        exm_we = 1'b1; exm_rd = 5'd3; exm_data = 32'd30;
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'd99;
`ifdef ID_EX_FORWARDING_EN
        applyStimulus(rType(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd7), 32'h0, 32'd7, 32'd11);
        exm_rd = 5'd5;
        applyStimulus(rType(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd7), 32'h0, 32'd7, 32'd11);
        exm_rd = 5'd4;
        applyStimulus(rType(7'b0000000, 5'd4, 5'd3, 3'b000, 5'd8), 32'h0, 32'd7, 32'd11);
`else
        for (int i = 0; i < 3; i++)
            applyStimulus(rType(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd7), 32'h0, 32'd7, 32'd11);
        exm_we = 1'b0; wb_we = 1'b0;
        applyStimulus(rType(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd7), 32'h0, 32'd7, 32'd11);
        exm_we = 1'b1;
`endif
        exm_rd = 5'd0; wb_rd = 5'd0;
        applyStimulus(rType(7'b0100000, 5'd4, 5'd0, 3'b000, 5'd7), 32'h0, 32'd123, 32'd11);
        exm_we = 1'b0; wb_we = 1'b0;

        applyStimulus(uType(20'h12345, 5'd10, 7'b0010111), 32'h100, 32'h0, 32'h0);
        applyStimulus(uType(20'hABCDE, 5'd11, 7'b0110111), 32'h200, 32'h55, 32'h0);
        applyStimulus(uType(20'hFFFFF, 5'd0, 7'b0110111), 32'h0, 32'h0, 32'h0);
        applyStimulus(32'h0020_8463, 32'h300, 32'h77, 32'h88);
        idle(1);

        out_ready = 1'b0;
        applyStimulus(rType(7'h0, 5'd3, 5'd2, 3'b000, 5'd1), 32'h0, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++)
            applyStimulus(rType(7'h0, 5'd5, 5'd4, 3'b110, 5'd6), 32'h0, 32'd4, 32'd8);
        out_ready = 1'b1;
        applyStimulus(rType(7'h0, 5'd5, 5'd4, 3'b110, 5'd6), 32'h0, 32'd4, 32'd8);
        applyStimulus(rType(7'h0, 5'd7, 5'd6, 3'b100, 5'd8), 32'h0, 32'hA5, 32'h5A);
        applyStimulus(iType(12'h800, 5'd1, 3'b000, 5'd2), 32'h0, 32'd9, 32'h0);
        idle(1);

        out_ready = 1'b0;
        applyStimulus(iType(12'h010, 5'd1, 3'b000, 5'd2), 32'h0, 32'd9, 32'h0);
        flush = 1'b1;
        applyStimulus(iType(12'h020, 5'd1, 3'b000, 5'd3), 32'h0, 32'd9, 32'h0);
        flush = 1'b0;
        idle(1);
        out_ready = 1'b1;
        flush = 1'b1;
        applyStimulus(iType(12'h030, 5'd1, 3'b000, 5'd4), 32'h0, 32'd9, 32'h0);
        flush = 1'b0;
        idle(1);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 4))
                0: rInstr = rType(($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000,
                                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                  3'($urandom), 5'($urandom_range(0, 3)));
                1: rInstr = iType(12'($urandom), 5'($urandom_range(0, 3)), 3'($urandom),
                                  5'($urandom_range(0, 3)));
                2: rInstr = uType(20'($urandom), 5'($urandom_range(0, 3)), 7'b0110111);
                3: rInstr = uType(20'($urandom), 5'($urandom_range(0, 3)), 7'b0010111);
                default: rInstr = {25'($urandom), 7'b0000011};
            endcase
            exm_we = ($urandom_range(0, 2) == 0); exm_rd = 5'($urandom_range(0, 3));
            exm_data = $urandom;
            wb_we = ($urandom_range(0, 2) == 0); wb_rd = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in_instr = rInstr;
            in_pc = $urandom;
            rs1_data = $urandom;
            rs2_data = $urandom;
            cycle();
        end
        exm_we = 1'b0; wb_we = 1'b0; flush = 1'b0; out_ready = 1'b1;
        idle(2);

        out_ready = 1'b0;
        applyStimulus(iType(12'h005, 5'd1, 3'b000, 5'd4), 32'h0, 32'd3, 32'h0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkAllZero("midreset");
        sb.delete();
        expValid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(iType(12'h006, 5'd1, 3'b000, 5'd4), 32'h0, 32'd3, 32'h0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
